// File: rtl/dmem_bus_ctrl_if.sv
// Core data-port and memory-bus signal bundle for the data-memory bus controller.
// The controller is the bus master; the core/memory environment takes the slave view.
interface dmem_bus_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic                MemRead;
    logic                MemWrite;
    logic [ADDR_W-1:0]   ALUResult;
    logic [31:0]         WriteData;
    logic [31:0]         ReadData;
    logic                Stall;
    logic                MisalignErr;
    logic                BusErr;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-3:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_ack;
    logic [31:0]         mem_rdata;

    modport master (
        input  MemRead, MemWrite, ALUResult, WriteData, mem_ack, mem_rdata,
        output ReadData, Stall, MisalignErr, BusErr,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output MemRead, MemWrite, ALUResult, WriteData, mem_ack, mem_rdata,
        input  ReadData, Stall, MisalignErr, BusErr,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns single-cycle core loads/stores into req/ack bus
// transactions, stalling the core while one is outstanding and flagging misalign/timeout.
module dmem_bus_ctrl #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic                 CLK,
    input  logic                 RST,
    dmem_bus_ctrl_if.master      bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic access;
    logic is_write;
    logic aligned;
    logic start;
    logic timeout;

    assign access   = bus.MemRead | bus.MemWrite;
    assign is_write = bus.MemWrite;
    assign aligned  = (bus.ALUResult[1:0] == 2'b00);
    assign start    = (state == IDLE) && access && aligned;
    // Ack takes priority: timeout only fires on the last REQ cycle with no ack.
    assign timeout  = (state == REQ) && !bus.mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

    // Combinational so the core freezes in the very cycle it presents an aligned access.
    assign bus.Stall = !RST && (start || (state == REQ));

    // Single-process FSM with registered bus outputs and status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.ReadData    <= '0;
            bus.MisalignErr <= 1'b0;
            bus.BusErr      <= 1'b0;
        end else begin
            bus.MisalignErr <= 1'b0;
            bus.BusErr      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= REQ;
                        cnt           <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= is_write;
                        bus.mem_addr  <= bus.ALUResult[ADDR_W-1:2];
                        bus.mem_wdata <= bus.WriteData;
                    end else if (access) begin
                        bus.MisalignErr <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) begin
                            bus.ReadData <= bus.mem_rdata;
                        end
                        bus.mem_req <= 1'b0;
                        state       <= DONE;
                    end else if (timeout) begin
                        if (!bus.mem_we) begin
                            bus.ReadData <= ERR_DATA;
                        end
                        bus.mem_req <= 1'b0;
                        bus.BusErr  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // The core retires the access here; returning to IDLE unconditionally
                // keeps the still-presented MemRead/MemWrite from being issued twice.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Randomized scoreboard bench for dmem_bus_ctrl: a core driver, a variable-latency memory
// responder and a monitor that checks bus transactions and completions against a queue.
module tb_dmem_bus_ctrl;
    localparam int unsigned TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_0BAD;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          mis;
        logic [31:0] rd;
        bit          berr;
        int          reqcyc;
    } done_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    logic inject_ack;

    int n_vec  = 0;
    int n_fail = 0;

    txn_t  txn_q[$];
    done_t done_q[$];
    resp_t resp_q[$];

    logic [31:0] model_rd;

    dmem_bus_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_bus_ctrl #(
        .ADDR_W  (32),
        .TIMEOUT (TMO),
        .ERR_DATA(ERR)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks on the lat-th REQ cycle, sprays ignored acks when idle.
    int    rcnt = 0;
    resp_t cur;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        cur = '{lat: 0, rdata: 32'h0};
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (rcnt == 0) begin
                    if (resp_q.size() != 0) cur = resp_q.pop_front();
                    else                    cur = '{lat: 0, rdata: 32'h0};
                end
                rcnt++;
                bus.mem_ack   = (rcnt == cur.lat);
                bus.mem_rdata = bus.mem_ack ? cur.rdata : $urandom();
            end else begin
                rcnt          = 0;
                bus.mem_ack   = inject_ack | ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom();
            end
        end
    end

    // Monitor: pops expected transactions on mem_req rise, completions on fall/MisalignErr.
    txn_t        mt;
    done_t       md;
    bit          prev_req = 1'b0;
    int          hi = 0;
    logic [31:0] mon_rd = '0;
    initial begin
        mt = '{we: 1'b0, addr: 30'h0, wdata: 32'h0};
        md = '{mis: 1'b0, rd: 32'h0, berr: 1'b0, reqcyc: 0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                chk("rst_mem_req",   32'(bus.mem_req),     32'd0);
                chk("rst_mem_we",    32'(bus.mem_we),      32'd0);
                chk("rst_mem_addr",  32'(bus.mem_addr),    32'd0);
                chk("rst_mem_wdata", bus.mem_wdata,        32'd0);
                chk("rst_ReadData",  bus.ReadData,         32'd0);
                chk("rst_BusErr",    32'(bus.BusErr),      32'd0);
                chk("rst_Misalign",  32'(bus.MisalignErr), 32'd0);
                mon_rd   = '0;
                prev_req = 1'b0;
                hi       = 0;
            end else begin
                if (bus.mem_req && !prev_req) begin
                    chk("txn_expected", 32'(txn_q.size() != 0), 32'd1);
                    if (txn_q.size() != 0) mt = txn_q.pop_front();
                    chk("mem_we",    32'(bus.mem_we),   32'(mt.we));
                    chk("mem_addr",  32'(bus.mem_addr), 32'(mt.addr));
                    chk("mem_wdata", bus.mem_wdata,     mt.wdata);
                    hi = 1;
                end else if (bus.mem_req) begin
                    chk("hold_we",    32'(bus.mem_we),   32'(mt.we));
                    chk("hold_addr",  32'(bus.mem_addr), 32'(mt.addr));
                    chk("hold_wdata", bus.mem_wdata,     mt.wdata);
                    hi++;
                end
                if (!bus.mem_req && prev_req) begin
                    chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                    if (done_q.size() != 0) md = done_q.pop_front();
                    chk("done_kind_bus", 32'(md.mis),    32'd0);
                    chk("req_cycles",    32'(hi),        32'(md.reqcyc));
                    chk("BusErr",        32'(bus.BusErr), 32'(md.berr));
                    mon_rd = md.rd;
                end else begin
                    chk("BusErr_quiet", 32'(bus.BusErr), 32'd0);
                end
                if (bus.MisalignErr) begin
                    chk("misalign_expected", 32'(done_q.size() != 0), 32'd1);
                    if (done_q.size() != 0) md = done_q.pop_front();
                    chk("done_kind_mis", 32'(md.mis), 32'd1);
                end
                chk("ReadData", bus.ReadData, mon_rd);
                prev_req = bus.mem_req;
            end
        end
    end

    task automatic idle(input int n);
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = $urandom();
        bus.WriteData = $urandom();
        repeat (n) @(negedge clk);
    endtask

    // One core access: the reference model predicts the bus transaction and its outcome.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        bit    acked;
        int    reqcyc;
        int    exp_stall;
        int    scnt;
        done_t d;
        bus.MemRead   = rd;
        bus.MemWrite  = wr;
        bus.ALUResult = addr;
        bus.WriteData = wdata;
        if (addr[1:0] == 2'b00) begin
            acked  = (lat >= 1) && (lat <= int'(TMO));
            reqcyc = acked ? lat : int'(TMO);
            if (!wr) model_rd = acked ? rdata : ERR;
            d = '{mis: 1'b0, rd: model_rd, berr: !acked, reqcyc: reqcyc};
            txn_q.push_back('{we: wr, addr: addr[31:2], wdata: wdata});
            resp_q.push_back('{lat: lat, rdata: rdata});
            exp_stall = reqcyc + 1;
        end else begin
            d = '{mis: 1'b1, rd: model_rd, berr: 1'b0, reqcyc: 0};
            exp_stall = 0;
        end
        done_q.push_back(d);
        scnt = 0;
        #1;
        while (bus.Stall === 1'b1 && scnt < 40) begin
            scnt++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(scnt), 32'(exp_stall));
        @(negedge clk);
    endtask

    // Reset lands in the 2nd REQ cycle; an ack one cycle later must be ignored.
    task automatic reset_mid();
        bus.MemRead   = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'h0000_0100;
        bus.WriteData = $urandom();
        txn_q.push_back('{we: 1'b0, addr: 30'h40, wdata: bus.WriteData});
        resp_q.push_back('{lat: 3, rdata: 32'h5555_AAAA});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("stall_rst_midreq", 32'(bus.Stall), 32'd0);
        @(posedge clk);
        #2 inject_ack = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.MemRead  = 1'b0;
        model_rd     = '0;
        #1 chk("stall_after_rst", 32'(bus.Stall), 32'd0);
        @(posedge clk);
        #2 inject_ack = 1'b0;
        @(negedge clk);
    endtask

    int          op;
    logic [31:0] a;
    initial begin
        rst           = 1'b1;
        inject_ack    = 1'b0;
        model_rd      = '0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        repeat (2) @(negedge clk);
        bus.MemRead   = 1'b1;
        bus.ALUResult = 32'h0000_0010;
        #1 chk("stall_in_reset", 32'(bus.Stall), 32'd0);
        @(negedge clk);
        bus.MemRead = 1'b0;
        rst         = 1'b0;
        idle(1);

        do_access(1'b1, 1'b0, 32'h0000_0010, $urandom(), 2, 32'hCAFE_F00D);
        idle(1);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, $urandom());
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0013, $urandom(), 1, $urandom());
        idle(1);
        do_access(1'b1, 1'b0, 32'h0000_0044, $urandom(), 0, $urandom());
        idle(2);
        do_access(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 3, $urandom());
        idle(1);

        for (int i = 0; i < 120; i++) begin
            op = int'($urandom_range(0, 2));
            a  = $urandom() & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_access(op != 1, op != 0, a, $urandom(), int'($urandom_range(0, 6)), $urandom());
            idle(int'($urandom_range(0, 2)));
        end

        reset_mid();
        idle(2);

        for (int i = 0; i < 10; i++) begin
            op = int'($urandom_range(0, 2));
            a  = $urandom() & 32'h0000_0FFC;
            do_access(op != 1, op != 0, a, $urandom(), int'($urandom_range(1, 6)), $urandom());
            idle(int'($urandom_range(0, 1)));
        end

        idle(8);
        chk("txn_q_drained",  32'(txn_q.size()),  32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares",
                 n_vec, n_fail);
        $fatal(1);
    end
endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
Data-memory bus controller placed directly downstream of the single-cycle MIPS core's data port.
- Consumes the core's MemRead, MemWrite, ALUResult (byte address) and WriteData.
- Converts each access into a req/ack transaction on a variable-latency memory bus.
- Returns ReadData to the core and drives Stall to hold PC and the core while a transaction is outstanding.
- Flags misaligned word accesses and bus timeouts.

Parameters:
- ADDR_W, 32, width of core byte address; bus word address width is ADDR_W-2.
- TIMEOUT, 16, maximum cycles in REQ before abort; legal range 2..255.
- ERR_DATA, 32'h0000_0000, ReadData value returned after a timed-out load.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- MemRead  in  1  core load request.
- MemWrite  in  1  core store request.
- ALUResult  in  ADDR_W  byte address from core.
- WriteData  in  32  store data from core.
- ReadData  out  32  load data to core, registered.
- Stall  out  1  hold core/PC this cycle.
- MisalignErr  out  1  one-cycle pulse, access with address[1:0]!=0.
- BusErr  out  1  one-cycle pulse, bus timeout.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  ADDR_W-2  word address (ALUResult[ADDR_W-1:2]), registered.
- mem_wdata  out  32  store data, registered.
- mem_ack  in  1  bus completion, single-cycle pulse.
- mem_rdata  in  32  read data, valid with mem_ack.

Behaviour:
Clocking and reset:
- One clock domain (CLK); RST is synchronous and active-high.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadData=0, MisalignErr=0, BusErr=0, timeout counter=0.
- Stall is forced to 0 while RST=1.

Access classification and request latching:
- access = MemRead|MemWrite.
- is_write = MemWrite; a store wins when MemRead and MemWrite are both high, and the read is dropped.
- Stall = (state==IDLE & access & ALUResult[1:0]==0) | (state==REQ). Stall is combinational.
- On the IDLE->REQ transition, register mem_req=1, mem_we=is_write, mem_addr and mem_wdata.

FSM states and transitions:
- IDLE:
  - Aligned access -> REQ.
  - Misaligned access -> MisalignErr=1 next cycle, no bus transaction, Stall=0, stay IDLE.
  - No access -> stay IDLE.
- REQ:
  - Hold mem_req and all bus outputs stable until mem_ack.
  - Counter increments every REQ cycle and clears on entry.
  - On mem_ack: if load, ReadData<=mem_rdata; if store, ReadData is unchanged. Then mem_req<=0 -> DONE.
  - If the counter reaches TIMEOUT-1 with no ack: mem_req<=0, BusErr=1 next cycle, ReadData<=ERR_DATA if load -> DONE.
  - Ack wins over timeout in the same cycle.
- DONE:
  - Stall=0; the core completes the instruction at this edge using ReadData.
  - Unconditionally -> IDLE, so the same MemRead/MemWrite still presented this cycle is not re-issued.

Latency and ordering:
- Minimum access, with ack in the first REQ cycle: 3 cycles, 2 of them stalled.
- mem_ack in IDLE or DONE is ignored.
- Only one outstanding transaction at a time.

Reset mid-transaction:
- RST in any state forces IDLE and mem_req=0 at that edge.
- A late ack arriving after reset is ignored, and ReadData resets to 0.

Test Plan:
- Load: ALUResult=0x0000_0010, MemRead=1; ack on the 2nd REQ cycle with rdata=0xCAFE_F00D -> mem_addr=0x4; Stall high for 3 cycles; ReadData=0xCAFE_F00D in DONE; mem_req low afterwards.
- Store: ALUResult=0x20, WriteData=0x1234_5678, MemWrite=1; ack in the 1st REQ cycle -> mem_we=1, mem_addr=0x8, mem_wdata=0x1234_5678; Stall high for exactly 2 cycles; ReadData unchanged.
- Misaligned: ALUResult=0x13, MemRead=1 -> Stall=0, mem_req never asserted, MisalignErr high for exactly 1 cycle.
- Timeout: TIMEOUT=4, load with no ack -> mem_req high 4 cycles then low; BusErr pulse; ReadData=ERR_DATA; FSM back in IDLE; a late ack is ignored.
- Simultaneous MemRead=MemWrite=1 at 0x40 -> single write transaction (mem_we=1), no read issued.
- Reset mid-REQ: assert RST in the 2nd REQ cycle, then ack one cycle later -> mem_req=0 after the reset edge, Stall=0, ReadData=0, no BusErr.
